// File: rtl/conv1x1_scheduler.sv
// Sequencer for the 16-lane 1x1 convolution datapath: walks pixel/oc/group, issues memory
// reads, times i_data_valid/firstvalue/bias, and writes each group sweep's final sum.
module conv1x1_scheduler #(
    parameter int DATWIDTH     = 16,
    parameter int LANES        = 16,
    parameter int INPUTCHANNEL = 64,
    parameter int OUTCHANNEL   = 64,
    parameter int INPUTSIZE    = 55,
    parameter int MEM_LAT      = 1,
    parameter int RELU         = 1,
    localparam int GROUPS  = INPUTCHANNEL / LANES,
    localparam int PIXELS  = INPUTSIZE * INPUTSIZE,
    localparam int IMG_AW  = (PIXELS * GROUPS > 1) ? $clog2(PIXELS * GROUPS) : 1,
    localparam int KER_AW  = (OUTCHANNEL * GROUPS > 1) ? $clog2(OUTCHANNEL * GROUPS) : 1,
    localparam int BIAS_AW = (OUTCHANNEL > 1) ? $clog2(OUTCHANNEL) : 1,
    localparam int OUT_AW  = (PIXELS * OUTCHANNEL > 1) ? $clog2(PIXELS * OUTCHANNEL) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                img_rd_en,
    output logic [IMG_AW-1:0]   img_rd_addr,
    output logic                ker_rd_en,
    output logic [KER_AW-1:0]   ker_rd_addr,
    output logic [BIAS_AW-1:0]  bias_rd_addr,
    output logic                conv_data_valid,
    output logic                conv_firstvalue,
    input  logic [DATWIDTH-1:0] conv_result,
    input  logic                conv_result_valid,
    output logic                out_wr_en,
    output logic [OUT_AW-1:0]   out_wr_addr,
    output logic [DATWIDTH-1:0] out_wr_data
);

    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int WCNT_W = $clog2(PIXELS * OUTCHANNEL + 1);

    localparam logic [GRP_W-1:0]   GRP_LAST   = GRP_W'(GROUPS - 1);
    localparam logic [BIAS_AW-1:0] OC_LAST    = BIAS_AW'(OUTCHANNEL - 1);
    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(PIXELS - 1);
    localparam logic [IMG_AW-1:0]  IMG_REWIND = IMG_AW'(GROUPS - 1);
    localparam logic [WCNT_W-1:0]  WR_TOTAL   = WCNT_W'(PIXELS * OUTCHANNEL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Bias must stay put from its group-0 issue until firstvalue samples it MEM_LAT+1 later.
    if (GROUPS < MEM_LAT + 2) begin : g_bad_groups
        $error("conv1x1_scheduler: GROUPS must be >= MEM_LAT+2");
    end
    if (INPUTCHANNEL % LANES != 0) begin : g_bad_lanes
        $error("conv1x1_scheduler: INPUTCHANNEL must be a multiple of LANES");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("conv1x1_scheduler: MEM_LAT must be >= 1");
    end

    logic [1:0]          state_q, state_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [BIAS_AW-1:0]  oc_q, oc_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
    logic [KER_AW-1:0]   ker_addr_q, ker_addr_d;
    logic [MEM_LAT-1:0]  vld_q, vld_d;
    logic [MEM_LAT:0]    first_q, first_d;
    logic [GRP_W-1:0]    rcnt_q, rcnt_d;
    logic [WCNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                out_wr_en_q, out_wr_en_d;
    logic [OUT_AW-1:0]   out_wr_addr_q, out_wr_addr_d;
    logic signed [DATWIDTH-1:0] out_wr_data_q, out_wr_data_d;

    logic issue;
    logic last_beat;
    logic pick;

    function automatic logic signed [DATWIDTH-1:0] relu_clamp(input logic signed [DATWIDTH-1:0] x);
        if ((RELU != 0) && x[DATWIDTH-1]) begin
            return '0;
        end
        return x;
    endfunction

    assign issue     = (state_q == S_ISSUE);
    assign last_beat = issue && (grp_q == GRP_LAST) && (oc_q == OC_LAST) && (pix_q == PIX_LAST);
    assign pick      = (state_q != S_IDLE) && conv_result_valid && (rcnt_q == GRP_LAST);

    always_comb begin
        state_d       = state_q;
        grp_d         = grp_q;
        oc_d          = oc_q;
        pix_d         = pix_q;
        img_addr_d    = img_addr_q;
        ker_addr_d    = ker_addr_q;
        rcnt_d        = rcnt_q;
        wr_cnt_d      = wr_cnt_q;
        out_wr_en_d   = 1'b0;
        out_wr_addr_d = out_wr_addr_q;
        out_wr_data_d = out_wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    grp_d      = '0;
                    oc_d       = '0;
                    pix_d      = '0;
                    img_addr_d = '0;
                    ker_addr_d = '0;
                    wr_cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end else if (grp_q == GRP_LAST) begin
                    grp_d = '0;
                    if (oc_q == OC_LAST) begin
                        // Last group of the last kernel: next pixel's base is one past here.
                        oc_d       = '0;
                        pix_d      = pix_q + 1'b1;
                        img_addr_d = img_addr_q + 1'b1;
                        ker_addr_d = '0;
                    end else begin
                        oc_d       = oc_q + 1'b1;
                        img_addr_d = img_addr_q - IMG_REWIND;
                        ker_addr_d = ker_addr_q + 1'b1;
                    end
                end else begin
                    grp_d      = grp_q + 1'b1;
                    img_addr_d = img_addr_q + 1'b1;
                    ker_addr_d = ker_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (wr_cnt_q == WR_TOTAL) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vld_d[0]   = issue;
        first_d[0] = issue && (grp_q == '0);
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        for (int i = 1; i <= MEM_LAT; i++) begin
            first_d[i] = first_q[i-1];
        end

        // Only the last partial sum of each group sweep reaches the output memory.
        if (state_q == S_IDLE) begin
            rcnt_d = '0;
        end else if (conv_result_valid) begin
            rcnt_d = (rcnt_q == GRP_LAST) ? '0 : rcnt_q + 1'b1;
        end
        if (pick) begin
            out_wr_en_d   = 1'b1;
            out_wr_addr_d = wr_cnt_q[OUT_AW-1:0];
            out_wr_data_d = relu_clamp(conv_result);
            wr_cnt_d      = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grp_q         <= '0;
            oc_q          <= '0;
            pix_q         <= '0;
            img_addr_q    <= '0;
            ker_addr_q    <= '0;
            vld_q         <= '0;
            first_q       <= '0;
            rcnt_q        <= '0;
            wr_cnt_q      <= '0;
            out_wr_en_q   <= 1'b0;
            out_wr_addr_q <= '0;
            out_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            grp_q         <= grp_d;
            oc_q          <= oc_d;
            pix_q         <= pix_d;
            img_addr_q    <= img_addr_d;
            ker_addr_q    <= ker_addr_d;
            vld_q         <= vld_d;
            first_q       <= first_d;
            rcnt_q        <= rcnt_d;
            wr_cnt_q      <= wr_cnt_d;
            out_wr_en_q   <= out_wr_en_d;
            out_wr_addr_q <= out_wr_addr_d;
            out_wr_data_q <= out_wr_data_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign img_rd_en       = issue;
    assign ker_rd_en       = issue;
    assign img_rd_addr     = img_addr_q;
    assign ker_rd_addr     = ker_addr_q;
    assign bias_rd_addr    = oc_q;
    assign conv_data_valid = vld_q[MEM_LAT-1];
    assign conv_firstvalue = first_q[MEM_LAT];
    assign out_wr_en       = out_wr_en_q;
    assign out_wr_addr     = out_wr_addr_q;
    assign out_wr_data     = out_wr_data_q;

endmodule

// File: tb/tb_conv1x1_scheduler.sv
// Bench for conv1x1_scheduler (GROUPS=3, OUTCHANNEL=2, INPUTSIZE=2, MEM_LAT=1) with a small
// behavioural memory + 16-lane MAC model standing in for conv2d1x1.
module tb_conv1x1_scheduler;

    localparam int NBEATS = 24;
    localparam int NWR    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        busy, done, img_rd_en, ker_rd_en, conv_data_valid, conv_firstvalue;
    logic [3:0]  img_rd_addr;
    logic [2:0]  ker_rd_addr;
    logic [0:0]  bias_rd_addr;
    logic        out_wr_en;
    logic [2:0]  out_wr_addr;
    logic [15:0] out_wr_data;

    logic        nr_busy, nr_done, nr_img_rd_en, nr_ker_rd_en, nr_conv_data_valid, nr_conv_firstvalue;
    logic [3:0]  nr_img_rd_addr;
    logic [2:0]  nr_ker_rd_addr;
    logic [0:0]  nr_bias_rd_addr;
    logic        nr_out_wr_en;
    logic [2:0]  nr_out_wr_addr;
    logic [15:0] nr_out_wr_data;

    logic [15:0] conv_result;
    logic        conv_result_valid;
    logic        man_en = 1'b0;
    logic        man_rv = 1'b0;
    logic [15:0] man_res = 16'h0000;

    conv1x1_scheduler #(.DATWIDTH(16), .LANES(16), .INPUTCHANNEL(48), .OUTCHANNEL(2),
                        .INPUTSIZE(2), .MEM_LAT(1), .RELU(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
        .ker_rd_en(ker_rd_en), .ker_rd_addr(ker_rd_addr), .bias_rd_addr(bias_rd_addr),
        .conv_data_valid(conv_data_valid), .conv_firstvalue(conv_firstvalue),
        .conv_result(conv_result), .conv_result_valid(conv_result_valid),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    conv1x1_scheduler #(.DATWIDTH(16), .LANES(16), .INPUTCHANNEL(48), .OUTCHANNEL(2),
                        .INPUTSIZE(2), .MEM_LAT(1), .RELU(0)) dut_nr (
        .clk(clk), .rst(rst), .start(start), .busy(nr_busy), .done(nr_done),
        .img_rd_en(nr_img_rd_en), .img_rd_addr(nr_img_rd_addr),
        .ker_rd_en(nr_ker_rd_en), .ker_rd_addr(nr_ker_rd_addr), .bias_rd_addr(nr_bias_rd_addr),
        .conv_data_valid(nr_conv_data_valid), .conv_firstvalue(nr_conv_firstvalue),
        .conv_result(conv_result), .conv_result_valid(conv_result_valid),
        .out_wr_en(nr_out_wr_en), .out_wr_addr(nr_out_wr_addr), .out_wr_data(nr_out_wr_data)
    );

    // Memories (1-cycle latency) and a 16-lane Q8.8 MAC with bias on firstvalue.
    logic [15:0] img_mem [12];
    logic [15:0] ker_mem [6];
    logic [15:0] bias_mem [2];
    logic [15:0] img_dq = '0, ker_dq = '0, bias_dq = '0, prod_sum = '0, acc = '0;
    logic        mult_vld = 1'b0, res_vld = 1'b0;

    function automatic logic [15:0] beat_sum(input logic [15:0] a, input logic [15:0] b);
        int ia, ib, p;
        ia = int'($signed(a));
        ib = int'($signed(b));
        p  = (ia * ib) >>> 8;
        return 16'(p * 16);
    endfunction

    always @(posedge clk) begin
        if (img_rd_en) img_dq <= img_mem[img_rd_addr];
        if (ker_rd_en) ker_dq <= ker_mem[ker_rd_addr];
        bias_dq <= bias_mem[bias_rd_addr];
        if (conv_data_valid) prod_sum <= beat_sum(img_dq, ker_dq);
        if (mult_vld) acc <= conv_firstvalue ? bias_dq + prod_sum : acc + prod_sum;
        if (rst) begin
            mult_vld <= 1'b0;
            res_vld  <= 1'b0;
        end else begin
            mult_vld <= conv_data_valid;
            res_vld  <= mult_vld;
        end
    end

    assign conv_result       = man_en ? man_res : acc;
    assign conv_result_valid = man_en ? man_rv  : res_vld;

    // Event logs captured on the falling edge.
    typedef struct { int cyc; int img; int ker; int bias; bit ker_en; } beat_log_t;
    typedef struct { int cyc; int addr; int data; int nr_data; bit nr_en; } wr_log_t;
    beat_log_t blog[$];
    wr_log_t   wlog[$];
    int        fvlog[$];
    int        dlog[$];
    int        cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (img_rd_en) blog.push_back('{cyc, int'(img_rd_addr), int'(ker_rd_addr), int'(bias_rd_addr), ker_rd_en});
        if (conv_firstvalue) fvlog.push_back(cyc);
        if (out_wr_en) wlog.push_back('{cyc, int'(out_wr_addr), int'(out_wr_data), int'(nr_out_wr_data), nr_out_wr_en});
        if (done) dlog.push_back(cyc);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] img_val;
        logic [15:0] ker_val;
        logic [15:0] bias_val;
        bit          repulse;
        logic [15:0] exp_relu;
        logic [15:0] exp_norelu;
    } pass_vec_t;

    pass_vec_t vecs[4];
    int exp_img [NBEATS] = '{0,1,2,0,1,2, 3,4,5,3,4,5, 6,7,8,6,7,8, 9,10,11,9,10,11};
    int exp_ker [NBEATS] = '{0,1,2,3,4,5, 0,1,2,3,4,5, 0,1,2,3,4,5, 0,1,2,3,4,5};
    int exp_bias[NBEATS] = '{0,0,0,1,1,1, 0,0,0,1,1,1, 0,0,0,1,1,1, 0,0,0,1,1,1};

    task automatic load_mems(input logic [15:0] iv, input logic [15:0] kv, input logic [15:0] bv);
        for (int i = 0; i < 12; i++) img_mem[i] = iv;
        for (int i = 0; i < 6; i++) ker_mem[i] = kv;
        for (int i = 0; i < 2; i++) bias_mem[i] = bv;
    endtask

    task automatic clear_logs();
        @(posedge clk);
        blog.delete();
        wlog.delete();
        fvlog.delete();
        dlog.delete();
    endtask

    task automatic run_pass(input string nm, input bit repulse);
        bit got_done;
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        got_done = 1'b0;
        for (int j = 0; j < 200 && !got_done; j++) begin
            if (j == 12) chk({nm, ".busy_mid"}, 32'(busy), 32'd1);
            start = repulse && (j == 5 || j == 25);
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        chk({nm, ".done_seen"}, 32'(got_done), 32'd1);
        repeat (3) @(negedge clk);
        chk({nm, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic verify_pass(input string nm, input logic [15:0] er, input logic [15:0] enr);
        chk({nm, ".beats"}, 32'(blog.size()), 32'(NBEATS));
        for (int i = 0; i < NBEATS && i < blog.size(); i++) begin
            chk($sformatf("%s.img_addr[%0d]", nm, i), 32'(blog[i].img), 32'(exp_img[i]));
            chk($sformatf("%s.ker_addr[%0d]", nm, i), 32'(blog[i].ker), 32'(exp_ker[i]));
            chk($sformatf("%s.bias_addr[%0d]", nm, i), 32'(blog[i].bias), 32'(exp_bias[i]));
            chk($sformatf("%s.ker_en[%0d]", nm, i), 32'(blog[i].ker_en), 32'd1);
            chk($sformatf("%s.beat_cyc[%0d]", nm, i), 32'(blog[i].cyc - blog[0].cyc), 32'(i));
        end
        chk({nm, ".fv_count"}, 32'(fvlog.size()), 32'd8);
        for (int k = 0; k < fvlog.size() && 3 * k < blog.size(); k++)
            chk($sformatf("%s.fv_cyc[%0d]", nm, k), 32'(fvlog[k]), 32'(blog[3*k].cyc + 2));
        chk({nm, ".writes"}, 32'(wlog.size()), 32'(NWR));
        for (int i = 0; i < wlog.size() && i < NWR; i++) begin
            chk($sformatf("%s.wr_addr[%0d]", nm, i), 32'(wlog[i].addr), 32'(i));
            chk($sformatf("%s.wr_data_relu[%0d]", nm, i), 32'(wlog[i].data), 32'(er));
            chk($sformatf("%s.wr_data_norelu[%0d]", nm, i), 32'(wlog[i].nr_data), 32'(enr));
            chk($sformatf("%s.nr_wr_en[%0d]", nm, i), 32'(wlog[i].nr_en), 32'd1);
        end
        chk({nm, ".done_count"}, 32'(dlog.size()), 32'd1);
        if (dlog.size() >= 1 && wlog.size() >= NWR)
            chk({nm, ".done_cyc"}, 32'(dlog[0]), 32'(wlog[NWR-1].cyc + 1));
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, ".busy"}, 32'(busy), 32'd0);
        chk({nm, ".done"}, 32'(done), 32'd0);
        chk({nm, ".img_rd_en"}, 32'(img_rd_en), 32'd0);
        chk({nm, ".img_rd_addr"}, 32'(img_rd_addr), 32'd0);
        chk({nm, ".ker_rd_en"}, 32'(ker_rd_en), 32'd0);
        chk({nm, ".ker_rd_addr"}, 32'(ker_rd_addr), 32'd0);
        chk({nm, ".bias_rd_addr"}, 32'(bias_rd_addr), 32'd0);
        chk({nm, ".conv_data_valid"}, 32'(conv_data_valid), 32'd0);
        chk({nm, ".conv_firstvalue"}, 32'(conv_firstvalue), 32'd0);
        chk({nm, ".out_wr_en"}, 32'(out_wr_en), 32'd0);
        chk({nm, ".out_wr_addr"}, 32'(out_wr_addr), 32'd0);
        chk({nm, ".out_wr_data"}, 32'(out_wr_data), 32'd0);
        chk({nm, ".nr_busy"}, 32'(nr_busy), 32'd0);
        chk({nm, ".nr_out_wr_data"}, 32'(nr_out_wr_data), 32'd0);
    endtask

    initial begin
        int nw;
        // Q8.8: 16 lanes x 3 groups x (1.0*1.0) + 2.0 = 50.0 = 0x3200
        vecs[0] = '{"ones",    16'h0100, 16'h0100, 16'h0200, 1'b0, 16'h3200, 16'h3200};
        vecs[1] = '{"negbias", 16'h0000, 16'h0100, 16'hF000, 1'b0, 16'h0000, 16'hF000};
        vecs[2] = '{"restart", 16'h0100, 16'h0100, 16'h0200, 1'b1, 16'h3200, 16'h3200};
        // 48 x (0.5 * -1.0) + 1.0 = -23.0 = 0xE900
        vecs[3] = '{"negsum",  16'h0080, 16'hFF00, 16'h0100, 1'b0, 16'h0000, 16'hE900};

        rst   = 1'b1;
        start = 1'b0;
        load_mems(16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Result-valid pulses while idle must not produce writes.
        man_en  = 1'b1;
        man_res = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            man_rv = (i < 3);
            @(negedge clk);
            chk($sformatf("idle_rv.out_wr_en[%0d]", i), 32'(out_wr_en), 32'd0);
        end
        man_rv = 1'b0;
        man_en = 1'b0;
        chk("idle_rv.busy", 32'(busy), 32'd0);

        foreach (vecs[v]) begin
            load_mems(vecs[v].img_val, vecs[v].ker_val, vecs[v].bias_val);
            run_pass(vecs[v].name, vecs[v].repulse);
            verify_pass(vecs[v].name, vecs[v].exp_relu, vecs[v].exp_norelu);
        end

        // Abort at beat 10, then a clean restart from address 0.
        load_mems(16'h0100, 16'h0100, 16'h0200);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort.beat10_img", 32'(img_rd_addr), 32'd4);
        chk("abort.beat10_ker", 32'(ker_rd_addr), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        nw = wlog.size();
        repeat (6) @(negedge clk);
        chk("abort.no_more_writes", 32'(wlog.size()), 32'(nw));
        chk("abort.no_done", 32'(dlog.size()), 32'd0);
        chk("abort.idle", 32'(busy), 32'd0);
        run_pass("after_abort", 1'b0);
        verify_pass("after_abort", 16'h3200, 16'h3200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
